vga_clk_en_gen: RTL and testbench

Parametrised multi-channel clock-enable generator for the video path. It runs entirely on one reference clock and derives NUM_CH independent fractional-rate strobes with a phase accumulator (NCO) per channel, plus a divide-by-two square wave per channel. Each channel's rate and phase can be reprogrammed at run time through a valid/ready port, and a `locked` indication covers every settling interval. It replaces fixed-frequency PLL outputs for pixel and line-timing logic that needs rates selectable at run time without reconfiguring the PLL.

---
 rtl/vga_clk_en_gen.sv | 144 ++++++++++++++
 tb/tb_vga_clk_en_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_clk_en_gen.sv
// Multi-channel NCO clock-enable generator: per-channel phase accumulators produce
// fractional-rate strobes and divide-by-two toggles, reprogrammable through a valid/ready port.
module vga_clk_en_gen #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned ACC_W       = 32,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_en,
    output logic [NUM_CH-1:0] clk_tog,
    output logic              locked
);

    localparam int unsigned CNT_W = $clog2(LOCK_CYCLES);

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;

    logic [ACC_W-1:0]   inc_q [NUM_CH];
    logic [ACC_W-1:0]   inc_d [NUM_CH];
    logic [ACC_W-1:0]   acc_q [NUM_CH];
    logic [ACC_W-1:0]   acc_d [NUM_CH];
    logic [ACC_W:0]     sum_c [NUM_CH];
    logic [NUM_CH-1:0]  en_q, en_d;
    logic [NUM_CH-1:0]  tog_q, tog_d;
    logic [NUM_CH-1:0]  load_c;

    logic               accept_c;
    logic               ch_ok_c;

    // Requests are only taken while locked; cfg_ready is the locked flag itself.
    assign accept_c = cfg_valid & locked_q;
    assign ch_ok_c  = ({1'b0, cfg_ch} < 5'(NUM_CH));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                    state_d = ST_LOCKED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOCKED: begin
                if (accept_c) begin
                    if (ch_ok_c) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
        endcase
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_SETTLE;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    // A load on a channel overrides that channel's accumulate step (and any carry).
    always_comb begin
        load_c = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            load_c[c] = accept_c & ch_ok_c & (cfg_ch == 4'(c));
        end
    end

    always_comb begin
        en_d  = '0;
        tog_d = tog_q;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            sum_c[c] = {1'b0, acc_q[c]} + {1'b0, inc_q[c]};
            inc_d[c] = inc_q[c];
            acc_d[c] = sum_c[c][ACC_W-1:0];
            if (load_c[c]) begin
                inc_d[c] = cfg_inc;
                acc_d[c] = cfg_phase;
                tog_d[c] = 1'b0;
            end else begin
                en_d[c]  = sum_c[c][ACC_W];
                tog_d[c] = tog_q[c] ^ sum_c[c][ACC_W];
            end
        end
    end

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                inc_q[c] <= '0;
                acc_q[c] <= '0;
            end
            en_q  <= '0;
            tog_q <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                inc_q[c] <= inc_d[c];
                acc_q[c] <= acc_d[c];
            end
            en_q  <= en_d;
            tog_q <= tog_d;
        end
    end

    assign cfg_ready = locked_q;
    assign locked    = locked_q;
    assign cfg_err   = err_q;
    assign clk_en    = en_q;
    assign clk_tog   = tog_q;

endmodule

// File: tb/tb_vga_clk_en_gen.sv
// Bench for vga_clk_en_gen: arithmetic reference model checked every cycle plus directed literal checks.
module tb_vga_clk_en_gen;

    localparam int unsigned NCH = 2;
    localparam int unsigned AW  = 8;
    localparam int unsigned LC  = 16;

    logic           refclk = 1'b0;
    logic           rst;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [3:0]     cfg_ch;
    logic [AW-1:0]  cfg_inc;
    logic [AW-1:0]  cfg_phase;
    logic           cfg_err;
    logic [NCH-1:0] clk_en;
    logic [NCH-1:0] clk_tog;
    logic           locked;

    int checks = 0;
    int errors = 0;

    vga_clk_en_gen #(
        .NUM_CH      (NCH),
        .ACC_W       (AW),
        .LOCK_CYCLES (LC)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_phase (cfg_phase),
        .cfg_err   (cfg_err),
        .clk_en    (clk_en),
        .clk_tog   (clk_tog),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: strobes/toggle derived from how many times P + n*I has wrapped 2^AW.
    bit [AW-1:0]     m_inc [NCH];
    bit [AW-1:0]     m_ph  [NCH];
    longint unsigned m_n   [NCH];
    bit [NCH-1:0]    m_en;
    bit [NCH-1:0]    m_tog;
    bit              m_locked;
    bit              m_err;
    int              m_since;

    function automatic longint unsigned wraps(input bit [AW-1:0] p, input bit [AW-1:0] i,
                                              input longint unsigned n);
        longint unsigned pp;
        longint unsigned ii;
        pp = p;
        ii = i;
        return (pp + n * ii) >> AW;
    endfunction

    always @(posedge refclk or negedge rst) begin : model
        bit acc_ok;
        longint unsigned w0;
        longint unsigned w1;
        if (!rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_inc[c] = '0;
                m_ph[c]  = '0;
                m_n[c]   = 0;
            end
            m_en     = '0;
            m_tog    = '0;
            m_locked = 1'b0;
            m_err    = 1'b0;
            m_since  = 0;
        end else begin
            acc_ok = cfg_valid && m_locked;
            m_err  = acc_ok && (cfg_ch >= 4'(NCH));
            for (int c = 0; c < NCH; c++) begin
                if (acc_ok && cfg_ch == 4'(c)) begin
                    m_inc[c] = cfg_inc;
                    m_ph[c]  = cfg_phase;
                    m_n[c]   = 0;
                    m_en[c]  = 1'b0;
                    m_tog[c] = 1'b0;
                end else begin
                    m_n[c]   = m_n[c] + 1;
                    w1       = wraps(m_ph[c], m_inc[c], m_n[c]);
                    w0       = wraps(m_ph[c], m_inc[c], m_n[c] - 1);
                    m_en[c]  = (w1 != w0);
                    m_tog[c] = w1[0];
                end
            end
            if (acc_ok && cfg_ch < 4'(NCH)) begin
                m_since  = 0;
                m_locked = 1'b0;
            end else begin
                if (m_since < int'(LC)) m_since++;
                m_locked = (m_since >= int'(LC));
            end
        end
    end

    always @(negedge refclk) begin
        if (rst === 1'b1) begin
            chk("model_clk_en",    64'(clk_en),    64'(m_en));
            chk("model_clk_tog",   64'(clk_tog),   64'(m_tog));
            chk("model_locked",    64'(locked),    64'(m_locked));
            chk("model_cfg_ready", 64'(cfg_ready), 64'(m_locked));
            chk("model_cfg_err",   64'(cfg_err),   64'(m_err));
        end
    end

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic wait_locked();
        int k;
        k = 0;
        while (locked !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        chk("wait_locked", 64'(locked), 64'd1);
    endtask

    task automatic do_cfg(input logic [3:0] ch, input logic [AW-1:0] inc, input logic [AW-1:0] ph);
        chk("ready_before_cfg", 64'(cfg_ready), 64'd1);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_inc   = inc;
        cfg_phase = ph;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic settle_after_reset();
        for (int e = 1; e <= int'(LC); e++) begin
            tick();
            chk($sformatf("settle_locked_c%0d", e), 64'(locked), 64'(e >= int'(LC)));
            chk($sformatf("settle_en_c%0d", e), 64'(clk_en), 64'd0);
            chk($sformatf("settle_tog_c%0d", e), 64'(clk_tog), 64'd0);
        end
    endtask

    initial begin
        int cnt;
        int adj;
        int k;
        logic prev;
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_inc   = '0;
        cfg_phase = '0;
        #1 rst = 1'b0;
        #2;
        chk("rst_clk_en",  64'(clk_en),    64'd0);
        chk("rst_clk_tog", 64'(clk_tog),   64'd0);
        chk("rst_locked",  64'(locked),    64'd0);
        chk("rst_ready",   64'(cfg_ready), 64'd0);
        chk("rst_err",     64'(cfg_err),   64'd0);
        tick();
        rst = 1'b1;
        settle_after_reset();

        // ch0 at half rate from phase 0: strobes after edges N+2, N+4, ...
        do_cfg(4'd0, 8'h80, 8'h00);
        chk("cfg0_locked_drop", 64'(locked), 64'd0);
        tick();
        chk("ch0_en_n1", 64'(clk_en[0]), 64'd0);
        tick();
        chk("ch0_en_n2",  64'(clk_en[0]),  64'd1);
        chk("ch0_tog_n2", 64'(clk_tog[0]), 64'd1);
        tick();
        tick();
        chk("ch0_en_n4",  64'(clk_en[0]),  64'd1);
        chk("ch0_tog_n4", 64'(clk_tog[0]), 64'd0);
        wait_locked();

        // ch1 at 0x55/256: 85 strobes over 256 cycles, never adjacent
        do_cfg(4'd1, 8'h55, 8'h00);
        cnt  = 0;
        adj  = 0;
        prev = 1'b0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (clk_en[1] === 1'b1) begin
                cnt++;
                if (prev) adj++;
            end
            prev = clk_en[1];
        end
        chk("ch1_strobe_count", 64'(cnt), 64'd85);
        chk("ch1_adjacent",     64'(adj), 64'd0);
        wait_locked();

        // Out-of-range channel
        do_cfg(4'd5, 8'h11, 8'h22);
        chk("bad_ch_err",    64'(cfg_err), 64'd1);
        chk("bad_ch_locked", 64'(locked),  64'd1);
        tick();
        chk("bad_ch_err_clr", 64'(cfg_err), 64'd0);
        chk("bad_ch_locked2", 64'(locked),  64'd1);

        // Reload ch0 on an edge where it would carry
        k = 0;
        while (clk_en[0] !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        chk("find_ch0_strobe", 64'(clk_en[0]), 64'd1);
        tick();
        do_cfg(4'd0, 8'h80, 8'hFF);
        chk("reload_en",  64'(clk_en[0]),  64'd0);
        chk("reload_tog", 64'(clk_tog[0]), 64'd0);
        tick();
        chk("reload_en_n1",  64'(clk_en[0]),  64'd1);
        chk("reload_tog_n1", 64'(clk_tog[0]), 64'd1);
        tick();
        chk("reload_en_n2", 64'(clk_en[0]), 64'd0);
        tick();
        chk("reload_en_n3",  64'(clk_en[0]),  64'd1);
        chk("reload_tog_n3", 64'(clk_tog[0]), 64'd0);
        wait_locked();

        // Asynchronous reset five cycles into a settle
        do_cfg(4'd1, 8'h40, 8'h10);
        repeat (5) tick();
        chk("pre_rst_locked", 64'(locked), 64'd0);
        #2 rst = 1'b0;
        #1;
        chk("async_clk_en",  64'(clk_en),    64'd0);
        chk("async_clk_tog", 64'(clk_tog),   64'd0);
        chk("async_locked",  64'(locked),    64'd0);
        chk("async_ready",   64'(cfg_ready), 64'd0);
        chk("async_err",     64'(cfg_err),   64'd0);
        tick();
        rst = 1'b1;
        settle_after_reset();
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
